// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter: PI loop filter between the delay-line phase detector and the DCO.
// Once per reference period it samples the synchronised error word, integrates it, and
// drives a clamped control word. Lock is flagged after a run of small-error updates.
//   fpga_clk_i    system clock
//   reset_n_i     asynchronous active-low reset
//   enable_i      synchronous loop enable; low clears the loop and aborts any update
//   reference_i   reference clock, asynchronous to fpga_clk_i
//   pd_error_i    signed phase error from the detector, asynchronous
//   dco_ctrl_o    registered DCO control word
//   ctrl_valid_o  one-cycle pulse marking a new dco_ctrl_o
//   lock_o        loop locked
module adpll_loop_filter #(
   parameter int unsigned PD_WIDTH     = 5,
   parameter int unsigned CTRL_WIDTH   = 10,
   parameter int unsigned ACC_WIDTH    = 16,
   parameter int unsigned KP_SHIFT     = 2,
   parameter int unsigned KI_SHIFT     = 0,
   parameter int unsigned NOMINAL_CTRL = 512,
   parameter int unsigned SAMPLE_DELAY = 4,
   parameter int unsigned LOCK_THRESH  = 1,
   parameter int unsigned LOCK_COUNT   = 8
) (
   input  logic                  fpga_clk_i,
   input  logic                  reset_n_i,
   input  logic                  enable_i,
   input  logic                  reference_i,
   input  logic [PD_WIDTH-1:0]   pd_error_i,
   output logic [CTRL_WIDTH-1:0] dco_ctrl_o,
   output logic                  ctrl_valid_o,
   output logic                  lock_o
);

   localparam int unsigned SUM_WIDTH = ACC_WIDTH + 2;
   localparam int unsigned CNT_WIDTH = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;
   localparam int unsigned LCK_WIDTH = $clog2(LOCK_COUNT + 1);

   localparam logic signed [SUM_WIDTH-1:0] ACC_MAX  = {3'b000, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_WIDTH-1:0] ACC_MIN  = {3'b111, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [SUM_WIDTH-1:0] CTRL_MAX = SUM_WIDTH'((2 ** CTRL_WIDTH) - 1);
   localparam logic signed [SUM_WIDTH-1:0] NOM_EXT  = SUM_WIDTH'(NOMINAL_CTRL);
   localparam logic [CNT_WIDTH-1:0]        CNT_INIT = CNT_WIDTH'(SAMPLE_DELAY - 1);
   localparam logic [LCK_WIDTH-1:0]        LCK_MAX  = LCK_WIDTH'(LOCK_COUNT);
   localparam logic [PD_WIDTH:0]           THRESH   = (PD_WIDTH+1)'(LOCK_THRESH);

   typedef enum logic [1:0] {StIdle, StWait, StUpdate, StOutput} state_e;

   state_e state_q, state_d;

   // Synchronisers: reference through two flops plus an edge-detect flop, error word through
   // two stages. The detector guarantees the word is settled well before capture.
   logic                ref_s1_q, ref_s2_q, ref_s3_q;
   logic [PD_WIDTH-1:0] pd_s1_q, err_q;
   logic                ref_rise;

   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic signed [PD_WIDTH-1:0]  err_r_q, err_r_d;
   logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
   logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
   logic [CTRL_WIDTH-1:0]       dco_q, dco_d;
   logic                        valid_q, valid_d;
   logic                        lock_q, lock_d;
   logic [LCK_WIDTH-1:0]        lock_cnt_q, lock_cnt_d;

   logic signed [SUM_WIDTH-1:0] err_ext, integ_sum;
   logic signed [ACC_WIDTH-1:0] integ_new;
   logic signed [PD_WIDTH:0]    err_wide;
   logic [PD_WIDTH:0]           err_abs;
   logic                        in_lock;
   logic [LCK_WIDTH-1:0]        lock_cnt_inc;

   assign ref_rise = ref_s2_q & ~ref_s3_q;

   always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ref_s1_q <= 1'b0;
         ref_s2_q <= 1'b0;
         ref_s3_q <= 1'b0;
         pd_s1_q  <= '0;
         err_q    <= '0;
      end else begin
         ref_s1_q <= reference_i;
         ref_s2_q <= ref_s1_q;
         ref_s3_q <= ref_s2_q;
         pd_s1_q  <= pd_error_i;
         err_q    <= pd_s1_q;
      end
   end

   // State register
   always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; edges seen outside StIdle are dropped, not queued
   always_comb begin
      state_d = state_q;
      if (!enable_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   if (ref_rise) state_d = StWait;
            StWait:   if (cnt_q == '0) state_d = StUpdate;
            StUpdate: state_d = StOutput;
            StOutput: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   // Arithmetic: error sign-extended before shifting; the wide sum absorbs the most
   // negative error and the saturated integrator without overflow.
   always_comb begin
      err_ext   = SUM_WIDTH'(err_r_q);
      integ_sum = SUM_WIDTH'(integ_q) + (err_ext <<< KI_SHIFT);
      if (integ_sum > ACC_MAX) begin
         integ_new = ACC_MAX[ACC_WIDTH-1:0];
      end else if (integ_sum < ACC_MIN) begin
         integ_new = ACC_MIN[ACC_WIDTH-1:0];
      end else begin
         integ_new = integ_sum[ACC_WIDTH-1:0];
      end
      err_wide     = (PD_WIDTH+1)'(err_r_q);
      err_abs      = (err_wide < 0) ? -err_wide : err_wide;
      in_lock      = (err_abs <= THRESH);
      lock_cnt_inc = (lock_cnt_q == LCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
   end

   // Datapath / output logic
   always_comb begin
      cnt_d      = cnt_q;
      err_r_d    = err_r_q;
      integ_d    = integ_q;
      sum_d      = sum_q;
      dco_d      = dco_q;
      valid_d    = 1'b0;
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt_q;
      if (!enable_i) begin
         integ_d    = '0;
         lock_cnt_d = '0;
         lock_d     = 1'b0;
         dco_d      = NOMINAL_CTRL[CTRL_WIDTH-1:0];
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ref_rise) cnt_d = CNT_INIT;
            end
            StWait: begin
               if (cnt_q == '0) begin
                  err_r_d = err_q;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StUpdate: begin
               integ_d = integ_new;
               sum_d   = NOM_EXT + (err_ext <<< KP_SHIFT) + SUM_WIDTH'(integ_new);
            end
            StOutput: begin
               if (sum_q < 0) begin
                  dco_d = '0;
               end else if (sum_q > CTRL_MAX) begin
                  dco_d = '1;
               end else begin
                  dco_d = sum_q[CTRL_WIDTH-1:0];
               end
               valid_d = 1'b1;
               if (in_lock) begin
                  lock_cnt_d = lock_cnt_inc;
                  lock_d     = (lock_cnt_inc == LCK_MAX);
               end else begin
                  lock_cnt_d = '0;
                  lock_d     = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q      <= '0;
         err_r_q    <= '0;
         integ_q    <= '0;
         sum_q      <= '0;
         dco_q      <= NOMINAL_CTRL[CTRL_WIDTH-1:0];
         valid_q    <= 1'b0;
         lock_q     <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         err_r_q    <= err_r_d;
         integ_q    <= integ_d;
         sum_q      <= sum_d;
         dco_q      <= dco_d;
         valid_q    <= valid_d;
         lock_q     <= lock_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign dco_ctrl_o   = dco_q;
   assign ctrl_valid_o = valid_q;
   assign lock_o       = lock_q;

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Scoreboard bench for adpll_loop_filter: each driven reference edge pushes the expected
// control word and lock state, and a monitor pops and compares on every valid pulse.
module tb_adpll_loop_filter;

   localparam int KP = 2;
   localparam int KI = 0;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       reference;
   logic [4:0] pd;
   logic [9:0] dco_ctrl_o;
   logic       ctrl_valid_o;
   logic       lock_o;

   typedef struct packed {
      logic [9:0] dco;
      logic       lock;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks     = 0;
   int   errors     = 0;
   int   valid_cnt  = 0;
   int   integ_m    = 0;
   int   lock_cnt_m = 0;
   int   snap;

   adpll_loop_filter dut (
      .fpga_clk_i   (clk),
      .reset_n_i    (rst_n),
      .enable_i     (enable),
      .reference_i  (reference),
      .pd_error_i   (pd),
      .dco_ctrl_o   (dco_ctrl_o),
      .ctrl_valid_o (ctrl_valid_o),
      .lock_o       (lock_o)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference model of one completed update
   function automatic void push_expect(input int e);
      int   sum;
      int   a;
      exp_t x;
      integ_m = integ_m + (e <<< KI);
      if (integ_m > 32767) integ_m = 32767;
      if (integ_m < -32768) integ_m = -32768;
      sum = 512 + (e <<< KP) + integ_m;
      if (sum < 0) sum = 0;
      if (sum > 1023) sum = 1023;
      a = (e < 0) ? -e : e;
      if (a <= 1) lock_cnt_m = (lock_cnt_m < 8) ? lock_cnt_m + 1 : 8;
      else lock_cnt_m = 0;
      x.dco  = 10'(sum);
      x.lock = (lock_cnt_m == 8);
      exp_q.push_back(x);
   endfunction

   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1 && ctrl_valid_o === 1'b1) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            check_value("spurious_valid", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check_value("dco", dco_ctrl_o, mon_e.dco);
            check_value("lock", lock_o, mon_e.lock);
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge
   task automatic send_edge(input int e, input bit timed);
      int lat;
      pd        = 5'(e);
      reference = 1'b1;
      push_expect(e);
      if (timed) begin
         lat = 0;
         for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) reference = 1'b0;
            if (ctrl_valid_o === 1'b1) lat = k;
         end
         reference = 1'b0;
         check_value("latency", lat, 9);
         repeat (2) @(posedge clk);
         #1;
      end else begin
         repeat (3) @(posedge clk);
         #1;
         reference = 1'b0;
         repeat (8) @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      integ_m    = 0;
      lock_cnt_m = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int pat[8];
      pat = '{-1, 0, 1, 1, 0, -1, 0, 1};
      rst_n     = 1'b0;
      enable    = 1'b0;
      reference = 1'b0;
      pd        = '0;
      repeat (3) @(posedge clk);
      #1;
      check_value("reset_dco", dco_ctrl_o, 512);
      check_value("reset_valid", ctrl_valid_o, 0);
      check_value("reset_lock", lock_o, 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Basic proportional + integral updates
      send_edge(3, 1'b1);
      check_value("first_dco", dco_ctrl_o, 527);
      send_edge(3, 1'b1);
      check_value("second_dco", dco_ctrl_o, 530);

      // Most negative error
      apply_reset();
      send_edge(-16, 1'b1);
      check_value("neg_dco", dco_ctrl_o, 432);

      // Output clamp, then integrator saturation over a long run
      apply_reset();
      repeat (31) send_edge(15, 1'b0);
      check_value("clamp_dco", dco_ctrl_o, 1023);
      repeat (2300) send_edge(15, 1'b0);
      check_value("sat_dco", dco_ctrl_o, 1023);

      // Lock acquire and loss
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         send_edge(pat[i], 1'b0);
         if (i == 6) check_value("lock_before_8", lock_o, 0);
      end
      check_value("lock_at_8", lock_o, 1);
      send_edge(2, 1'b0);
      check_value("lock_lost", lock_o, 0);

      // Edges every 3 cycles: only every third is accepted
      apply_reset();
      snap = valid_cnt;
      pd   = '0;
      repeat (4) push_expect(0);
      repeat (12) begin
         reference = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         reference = 1'b0;
         @(posedge clk);
         #1;
      end
      repeat (12) @(posedge clk);
      #1;
      check_value("fast_valid_cnt", valid_cnt - snap, 4);
      check_value("fast_queue_empty", exp_q.size(), 0);

      // Build up lock and a non-nominal word, then abort mid-WAIT with enable low
      repeat (4) send_edge(1, 1'b0);
      check_value("pre_abort_lock", lock_o, 1);
      snap      = valid_cnt;
      pd        = 5'd3;
      reference = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) reference = 1'b0;
      end
      enable     = 1'b0;
      integ_m    = 0;
      lock_cnt_m = 0;
      repeat (8) @(posedge clk);
      #1;
      check_value("abort_no_valid", valid_cnt - snap, 0);
      check_value("disable_dco", dco_ctrl_o, 512);
      check_value("disable_lock", lock_o, 0);
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send_edge(5, 1'b1);
      check_value("reenable_dco", dco_ctrl_o, 537);

      // Async reset while in UPDATE
      snap      = valid_cnt;
      pd        = 5'd5;
      reference = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) reference = 1'b0;
      end
      rst_n      = 1'b0;
      integ_m    = 0;
      lock_cnt_m = 0;
      #1;
      check_value("midreset_dco", dco_ctrl_o, 512);
      check_value("midreset_lock", lock_o, 0);
      check_value("midreset_valid", ctrl_valid_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_value("midreset_no_valid", valid_cnt - snap, 0);
      send_edge(3, 1'b1);
      check_value("post_reset_dco", dco_ctrl_o, 527);
      check_value("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
